fft_result_sink: RTL and testbench
==================================

FFT_RESULT_SINK -- requirements
Module: fft_result_sink

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning signed width of each real/imag component.
REQ-002 SHALL have parameter NFFT_LOG2, default 10, meaning log2 of FFT frame length N (N=1024).
REQ-003 SHALL have port sys_clk, input, 1, meaning sole clock; all logic rising-edge.
REQ-004 SHALL have port sys_rst_n, input, 1, meaning reset, asynchronous assert, active-low.
REQ-005 SHALL have port s_axis_tdata, input, 2*DATA_W, meaning {imag[DATA_W-1:0], real[DATA_W-1:0]}, two's complement.
REQ-006 SHALL have port s_axis_tvalid, input, 1, meaning beat valid from FFT core.
REQ-007 SHALL have port s_axis_tlast, input, 1, meaning last bin of frame.
REQ-008 SHALL have port s_axis_tready, output, 1, meaning sink accepts beat.
REQ-009 SHALL have port peak_bin, output, NFFT_LOG2, meaning index of max-magnitude bin of last completed frame.
REQ-010 SHALL have port peak_mag, output, 2*DATA_W+1, meaning re^2+im^2 of peak bin, unsigned.
REQ-011 SHALL have port frame_done, output, 1, meaning one-cycle pulse when peak_bin/peak_mag update.
REQ-012 SHALL have port frame_cnt, output, 16, meaning completed frames, wraps 0xFFFF->0.
REQ-013 SHALL have port err_early, output, 1, meaning sticky: tlast seen before bin N-1.
REQ-014 SHALL have port err_late, output, 1, meaning sticky: bin N-1 accepted without tlast.

Function
REQ-015 SHALL accept a beat only when s_axis_tvalid and s_axis_tready are both 1 on a sys_clk edge.
REQ-016 SHALL implement states IDLE, RECV, DRAIN, REPORT; tready=1 in IDLE/RECV, 0 in DRAIN/REPORT.
REQ-017 IDLE->RECV on first accepted beat (bin 0); RECV->DRAIN on accepted beat with tlast=1 or bin counter = N-1; DRAIN (2 cycles)->REPORT (1 cycle)->IDLE.
REQ-018 SHALL count bin index per accepted beat, starting 0 each frame, NFFT_LOG2 bits.
REQ-019 SHALL compute magnitude re*re+im*im in one registered stage, full 2*DATA_W+1 width, no truncation or saturation; (-2^(DATA_W-1))^2 x2 = 2^(2*DATA_W-1) SHALL be exact.
REQ-020 SHALL compare registered magnitude against running max in the next stage; strictly greater replaces, ties keep lowest bin.
REQ-021 Running max SHALL be cleared to 0/bin 0 at each frame start so bin 0 is always a candidate.
REQ-022 frame_done SHALL pulse in REPORT, exactly 3 cycles after the accepted frame-ending beat; peak_bin/peak_mag/frame_cnt update the same cycle and hold until next REPORT.
REQ-023 tlast at bin k<N-1 SHALL set err_early and end the frame at k; results still reported.
REQ-024 Bin N-1 accepted without tlast SHALL set err_late and end the frame.
REQ-025 tvalid low mid-frame SHALL stall the bin counter and pipeline without losing state.
REQ-026 err_early/err_late SHALL clear only on reset.

Reset
REQ-027 sys_rst_n low SHALL immediately force state IDLE, s_axis_tready=0 while low, peak_bin=0, peak_mag=0, frame_done=0, frame_cnt=0, err_early=0, err_late=0, bin counter and pipeline cleared.
REQ-028 Reset mid-frame SHALL discard the partial frame; no frame_done for it.
REQ-029 s_axis_tready SHALL go 1 on the first sys_clk edge after reset release.

Configuration
REQ-030 With FFT_SINK_HALF_SPECTRUM_EN defined, only bins 0..N/2-1 SHALL be peak candidates; bins N/2..N-1 are accepted and counted but ignored by compare.
REQ-031 Without FFT_SINK_HALF_SPECTRUM_EN, all N bins SHALL be candidates.

Structure
REQ-032 State encoding enum and magnitude width constant SHALL live in shared package fft_pkg.
REQ-033 Squaring stage SHALL be sub-module fft_mag_sq (registered, valid-qualified, one-cycle latency).

Verification
REQ-034 Frame with bin 37 = {re=1000, im=-1000}, others 0, tlast at 1023 -> frame_done 3 cycles later, peak_bin=37, peak_mag=2000000, frame_cnt=1.
REQ-035 Bins 5 and 900 both {re=-32768, im=-32768} -> peak_bin=5, peak_mag=2147483648; with FFT_SINK_HALF_SPECTRUM_EN and only bin 900 nonzero -> peak_bin=0, peak_mag=0.
REQ-036 tlast at bin 511 -> err_early=1, frame ends, frame_done pulses, next frame starts at bin 0.
REQ-037 1024 beats, no tlast -> err_late=1, frame_done pulses after beat 1023.
REQ-038 Random tvalid gaps (50%) over 3 frames -> results identical to gapless run, frame_cnt=3.
REQ-039 Assert sys_rst_n=0 at bin 300 -> all outputs 0 immediately, no frame_done; next full frame reports correctly with frame_cnt=1.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared definitions for the FFT result sink: FSM state encoding and the
// squared-magnitude width helper.
package fft_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RECV   = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_REPORT = 2'd3
    } sink_state_t;

    // re^2 + im^2 of two signed components needs one bit more than a single product
    function automatic int fft_mag_w(input int data_w);
        return 2 * data_w + 1;
    endfunction

endpackage

// File: rtl/fft_mag_sq.sv
// Registered squared-magnitude stage: mag = re*re + im*im, one-cycle latency,
// carrying a bin tag and valid alongside the result.
module fft_mag_sq
    import fft_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int TAG_W  = 10
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_vld,
    input  logic [2*DATA_W-1:0]            in_data,
    input  logic [TAG_W-1:0]               in_tag,
    output logic                           mag_vld,
    output logic [fft_mag_w(DATA_W)-1:0]   mag,
    output logic [TAG_W-1:0]               mag_tag
);

    localparam int MAG_W = fft_mag_w(DATA_W);

    logic signed [DATA_W-1:0]   re_s;
    logic signed [DATA_W-1:0]   im_s;
    logic signed [2*DATA_W-1:0] re_sq_s;
    logic signed [2*DATA_W-1:0] im_sq_s;
    logic [MAG_W-1:0]           sum_s;

    // Squares are non-negative and fit in 2*DATA_W bits; the extra top bit holds the sum carry
    always_comb begin
        re_s    = in_data[DATA_W-1:0];
        im_s    = in_data[2*DATA_W-1:DATA_W];
        re_sq_s = re_s * re_s;
        im_sq_s = im_s * im_s;
        sum_s   = {1'b0, re_sq_s} + {1'b0, im_sq_s};
    end

    // Pipeline register, result only loaded on a valid beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mag_vld <= 1'b0;
            mag     <= {MAG_W{1'b0}};
            mag_tag <= {TAG_W{1'b0}};
        end else begin
            mag_vld <= in_vld;
            if (in_vld) begin
                mag     <= sum_s;
                mag_tag <= in_tag;
            end else begin
                mag     <= mag;
                mag_tag <= mag_tag;
            end
        end
    end

endmodule

// File: rtl/fft_result_sink.sv
// AXI-Stream sink for FFT output frames: finds the peak-magnitude bin per frame.
// Define FFT_SINK_HALF_SPECTRUM_EN to restrict peak candidates to bins 0..N/2-1.
module fft_result_sink
    import fft_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int NFFT_LOG2 = 10
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst_n,
    input  logic [2*DATA_W-1:0]           s_axis_tdata,
    input  logic                          s_axis_tvalid,
    input  logic                          s_axis_tlast,
    output logic                          s_axis_tready,
    output logic [NFFT_LOG2-1:0]          peak_bin,
    output logic [fft_mag_w(DATA_W)-1:0]  peak_mag,
    output logic                          frame_done,
    output logic [15:0]                   frame_cnt,
    output logic                          err_early,
    output logic                          err_late
);

    localparam int                   MAG_W    = fft_mag_w(DATA_W);
    localparam logic [NFFT_LOG2-1:0] LAST_BIN = {NFFT_LOG2{1'b1}};

    sink_state_t          state_r;
    logic [NFFT_LOG2-1:0] bin_cnt_r;
    logic                 drain_cnt_r;
    logic [MAG_W-1:0]     max_mag_r;
    logic [NFFT_LOG2-1:0] max_bin_r;

    logic                 accept_s;
    logic                 last_bin_s;
    logic                 frame_end_s;
    logic                 frame_start_s;
    logic                 cand_s;
    logic                 mag_vld_s;
    logic [MAG_W-1:0]     mag_s;
    logic [NFFT_LOG2-1:0] mag_bin_s;

    // Handshake and frame-boundary decode
    always_comb begin
        accept_s      = s_axis_tvalid & s_axis_tready;
        last_bin_s    = (bin_cnt_r == LAST_BIN);
        frame_end_s   = accept_s & (s_axis_tlast | last_bin_s);
        frame_start_s = accept_s & (state_r == ST_IDLE);
    end

    fft_mag_sq #(
        .DATA_W (DATA_W),
        .TAG_W  (NFFT_LOG2)
    ) u_mag_sq (
        .clk     (sys_clk),
        .rst_n   (sys_rst_n),
        .in_vld  (accept_s),
        .in_data (s_axis_tdata),
        .in_tag  (bin_cnt_r),
        .mag_vld (mag_vld_s),
        .mag     (mag_s),
        .mag_tag (mag_bin_s)
    );

    // Candidate filter on the tagged bin leaving the squaring stage
    always_comb begin
`ifdef FFT_SINK_HALF_SPECTRUM_EN
        cand_s = (mag_bin_s[NFFT_LOG2-1] == 1'b0);
`else
        cand_s = 1'b1;
`endif
    end

    // Running max: cleared on the first beat of a frame, strict greater keeps lowest bin on ties
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            max_mag_r <= {MAG_W{1'b0}};
            max_bin_r <= {NFFT_LOG2{1'b0}};
        end else if (frame_start_s) begin
            max_mag_r <= {MAG_W{1'b0}};
            max_bin_r <= {NFFT_LOG2{1'b0}};
        end else if (mag_vld_s && cand_s && (mag_s > max_mag_r)) begin
            max_mag_r <= mag_s;
            max_bin_r <= mag_bin_s;
        end else begin
            max_mag_r <= max_mag_r;
            max_bin_r <= max_bin_r;
        end
    end

    // Frame FSM with registered ready, report and sticky error outputs
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_r       <= ST_IDLE;
            s_axis_tready <= 1'b0;
            bin_cnt_r     <= {NFFT_LOG2{1'b0}};
            drain_cnt_r   <= 1'b0;
            frame_done    <= 1'b0;
            peak_bin      <= {NFFT_LOG2{1'b0}};
            peak_mag      <= {MAG_W{1'b0}};
            frame_cnt     <= 16'd0;
            err_early     <= 1'b0;
            err_late      <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (accept_s && s_axis_tlast && !last_bin_s) begin
                err_early <= 1'b1;
            end else if (accept_s && !s_axis_tlast && last_bin_s) begin
                err_late <= 1'b1;
            end else begin
                err_early <= err_early;
                err_late  <= err_late;
            end
            case (state_r)
                ST_IDLE, ST_RECV: begin
                    s_axis_tready <= 1'b1;
                    drain_cnt_r   <= 1'b0;
                    if (frame_end_s) begin
                        state_r       <= ST_DRAIN;
                        s_axis_tready <= 1'b0;
                        bin_cnt_r     <= {NFFT_LOG2{1'b0}};
                    end else if (accept_s) begin
                        state_r   <= ST_RECV;
                        bin_cnt_r <= bin_cnt_r + {{(NFFT_LOG2-1){1'b0}}, 1'b1};
                    end else begin
                        state_r <= state_r;
                    end
                end
                // Two drain cycles let the last beat clear the square and compare stages
                ST_DRAIN: begin
                    s_axis_tready <= 1'b0;
                    if (drain_cnt_r) begin
                        state_r     <= ST_REPORT;
                        drain_cnt_r <= 1'b0;
                        frame_done  <= 1'b1;
                        peak_bin    <= max_bin_r;
                        peak_mag    <= max_mag_r;
                        frame_cnt   <= frame_cnt + 16'd1;
                    end else begin
                        drain_cnt_r <= 1'b1;
                    end
                end
                ST_REPORT: begin
                    state_r       <= ST_IDLE;
                    s_axis_tready <= 1'b1;
                end
                default: begin
                    state_r       <= ST_IDLE;
                    s_axis_tready <= 1'b0;
                    bin_cnt_r     <= {NFFT_LOG2{1'b0}};
                    drain_cnt_r   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft_result_sink.sv
// Directed, table-driven bench for fft_result_sink: one frame per table row,
// plus hand-written reset sequences. Honors FFT_SINK_HALF_SPECTRUM_EN.
module tb_fft_result_sink;

    localparam int DATA_W = 16;
    localparam int NL     = 10;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tlast;
    logic        s_axis_tready;
    logic [9:0]  peak_bin;
    logic [32:0] peak_mag;
    logic        frame_done;
    logic [15:0] frame_cnt;
    logic        err_early;
    logic        err_late;

    fft_result_sink #(.DATA_W(DATA_W), .NFFT_LOG2(NL)) dut (
        .sys_clk       (sys_clk),
        .sys_rst_n     (sys_rst_n),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .peak_bin      (peak_bin),
        .peak_mag      (peak_mag),
        .frame_done    (frame_done),
        .frame_cnt     (frame_cnt),
        .err_early     (err_early),
        .err_late      (err_late)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        int          a_bin; int a_re; int a_im;
        int          b_bin; int b_re; int b_im;
        int          len;
        bit          has_last;
        bit          gaps;
        int          exp_bin;
        logic [32:0] exp_mag;
        bit          exp_early;
        bit          exp_late;
    } vec_t;

    vec_t vecs[9];
    int   n_cmp   = 0;
    int   n_err   = 0;
    int   exp_cnt = 0;

    function automatic logic [31:0] pack(input int re, input int im);
        logic [15:0] r;
        logic [15:0] i;
        r = re[15:0];
        i = im[15:0];
        return {i, r};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic send_beat(input logic [31:0] d, input logic last);
        int waited;
        bit done;
        waited = 0;
        done   = 1'b0;
        while (!done) begin
            @(negedge sys_clk);
            s_axis_tdata  = d;
            s_axis_tvalid = 1'b1;
            s_axis_tlast  = last;
            if (s_axis_tready) begin
                @(posedge sys_clk);
                done = 1'b1;
            end else begin
                waited++;
                if (waited > 20) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL beat_accept: tready held at 0, expected 1");
                    done = 1'b1;
                end
            end
        end
    endtask

    task automatic gap_cycle();
        @(negedge sys_clk);
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = $urandom;
        s_axis_tlast  = 1'($urandom_range(0, 1));
    endtask

    task automatic send_frame(input vec_t v, input int stop_at);
        logic [31:0] d;
        for (int b = 0; b < stop_at; b++) begin
            if (v.gaps && ($urandom_range(0, 1) == 1)) gap_cycle();
            if (b == v.a_bin)      d = pack(v.a_re, v.a_im);
            else if (b == v.b_bin) d = pack(v.b_re, v.b_im);
            else                   d = 32'd0;
            send_beat(d, v.has_last && (b == v.len - 1));
        end
    endtask

    // Called right after the posedge that accepted the frame-ending beat
    task automatic check_report(input vec_t v, input int idx);
        exp_cnt++;
        @(negedge sys_clk);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        check($sformatf("v%0d_done_c1", idx), 64'(frame_done), 64'd0);
        check($sformatf("v%0d_ready_drain", idx), 64'(s_axis_tready), 64'd0);
        @(negedge sys_clk);
        check($sformatf("v%0d_done_c2", idx), 64'(frame_done), 64'd0);
        @(negedge sys_clk);
        check($sformatf("v%0d_done_c3", idx), 64'(frame_done), 64'd1);
        check($sformatf("v%0d_peak_bin", idx), 64'(peak_bin), 64'(v.exp_bin));
        check($sformatf("v%0d_peak_mag", idx), 64'(peak_mag), 64'(v.exp_mag));
        check($sformatf("v%0d_frame_cnt", idx), 64'(frame_cnt), 64'(exp_cnt));
        check($sformatf("v%0d_err_early", idx), 64'(err_early), 64'(v.exp_early));
        check($sformatf("v%0d_err_late", idx), 64'(err_late), 64'(v.exp_late));
        @(negedge sys_clk);
        check($sformatf("v%0d_done_c4", idx), 64'(frame_done), 64'd0);
        check($sformatf("v%0d_ready_idle", idx), 64'(s_axis_tready), 64'd1);
        check($sformatf("v%0d_peak_hold", idx), 64'(peak_bin), 64'(v.exp_bin));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, 64'(s_axis_tready), 64'd0);
        check({tag, "_peak_bin"}, 64'(peak_bin), 64'd0);
        check({tag, "_peak_mag"}, 64'(peak_mag), 64'd0);
        check({tag, "_done"}, 64'(frame_done), 64'd0);
        check({tag, "_frame_cnt"}, 64'(frame_cnt), 64'd0);
        check({tag, "_err_early"}, 64'(err_early), 64'd0);
        check({tag, "_err_late"}, 64'(err_late), 64'd0);
    endtask

    initial begin
        //           a_bin a_re    a_im    b_bin b_re    b_im    len  last gaps exp_bin exp_mag                 early late
        vecs[0] = '{ 37,   1000,  -1000,  -1,    0,      0,      1024, 1'b1, 1'b0, 37,   33'd2000000,          1'b0, 1'b0};
        vecs[1] = '{ 5,   -32768, -32768,  900, -32768, -32768,  1024, 1'b1, 1'b0, 5,    33'd2147483648,       1'b0, 1'b0};
`ifdef FFT_SINK_HALF_SPECTRUM_EN
        vecs[2] = '{ 900,  300,    400,   -1,    0,      0,      1024, 1'b1, 1'b0, 0,    33'd0,                1'b0, 1'b0};
        vecs[3] = '{ 0,    1,      1,      1023, -1,     2,      1024, 1'b1, 1'b1, 0,    33'd2,                1'b0, 1'b0};
`else
        vecs[2] = '{ 900,  300,    400,   -1,    0,      0,      1024, 1'b1, 1'b0, 900,  33'd250000,           1'b0, 1'b0};
        vecs[3] = '{ 0,    1,      1,      1023, -1,     2,      1024, 1'b1, 1'b1, 1023, 33'd5,                1'b0, 1'b0};
`endif
        vecs[4] = '{ 10,   3,      4,      20,  -4,     -3,      1024, 1'b1, 1'b1, 10,   33'd25,               1'b0, 1'b0};
        vecs[5] = '{ -1,   0,      0,     -1,    0,      0,      1024, 1'b1, 1'b1, 0,    33'd0,                1'b0, 1'b0};
        vecs[6] = '{ 100,  7,      0,     -1,    0,      0,      512,  1'b1, 1'b0, 100,  33'd49,               1'b1, 1'b0};
        vecs[7] = '{ 0,    2,      0,     -1,    0,      0,      1024, 1'b1, 1'b0, 0,    33'd4,                1'b1, 1'b0};
`ifdef FFT_SINK_HALF_SPECTRUM_EN
        vecs[8] = '{ 1023, 0,     -5,     -1,    0,      0,      1024, 1'b0, 1'b0, 0,    33'd0,                1'b1, 1'b1};
`else
        vecs[8] = '{ 1023, 0,     -5,     -1,    0,      0,      1024, 1'b0, 1'b0, 1023, 33'd25,               1'b1, 1'b1};
`endif

        sys_rst_n     = 1'b0;
        s_axis_tdata  = 32'd0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        repeat (3) @(negedge sys_clk);
        check_all_zero("rst");
        sys_rst_n = 1'b1;
        #1;
        check("rst_rel_ready_low", 64'(s_axis_tready), 64'd0);
        @(negedge sys_clk);
        check("rst_rel_ready_first_edge", 64'(s_axis_tready), 64'd1);

        for (int i = 0; i < 9; i++) begin
            send_frame(vecs[i], vecs[i].len);
            check_report(vecs[i], i);
        end

        // Reset in the middle of a frame: partial frame must vanish without a report
        send_frame(vecs[0], 300);
        @(negedge sys_clk);
        sys_rst_n     = 1'b0;
        s_axis_tvalid = 1'b0;
        #1;
        check_all_zero("midrst");
        for (int c = 0; c < 4; c++) begin
            @(negedge sys_clk);
            check($sformatf("midrst_no_done_%0d", c), 64'(frame_done), 64'd0);
        end
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        check("midrst_ready_first_edge", 64'(s_axis_tready), 64'd1);
        exp_cnt = 0;
        send_frame(vecs[0], vecs[0].len);
        check_report(vecs[0], 9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
